// File: rtl/tile_seq_controller_pkg.sv
// rtl/tile_seq_controller_pkg.sv - state encoding and memory strobe levels for the tile sequencer
package tile_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_A,
      S_CALC,
      S_DRAIN,
      S_STORE,
      S_FINISH
   } seq_state_e;

   // All buffers use active-low chip enable and write enable
   localparam logic CEN_ON  = 1'b0;
   localparam logic CEN_OFF = 1'b1;
   localparam logic WEN_WR  = 1'b0;
   localparam logic WEN_RD  = 1'b1;

endpackage

// File: rtl/tile_seq_controller_if.sv
// rtl/tile_seq_controller_if.sv - control, config and buffer-port bundle of the tile sequencer
interface tile_seq_controller_if #(
   parameter int ADDR_W = 6,
   parameter int LEN_W  = 6,
   parameter int TILE_W = 4
);
   logic              EN;
   logic              START;
   logic [ADDR_W-1:0] W_BASE, A_BASE, O_BASE;
   logic [LEN_W-1:0]  W_LEN, A_LEN, O_LEN;
   logic [TILE_W-1:0] NUM_TILES;

   logic              BUSY, DONE, ERR;
   logic [TILE_W-1:0] TILE_IDX;
   logic              W_EN, SELECTOR;

   logic              share_cen, share_wen;
   logic [ADDR_W-1:0] share_addr;
   logic              weight_cen, weight_wen;
   logic [ADDR_W-1:0] weight_addr;
   logic              act_cen, act_wen;
   logic [ADDR_W-1:0] act_addr;
   logic              out_cen, out_wen;
   logic [ADDR_W-1:0] out_addr;

   modport master (
      output EN, START, W_BASE, A_BASE, O_BASE, W_LEN, A_LEN, O_LEN, NUM_TILES,
      input  BUSY, DONE, ERR, TILE_IDX, W_EN, SELECTOR,
      input  share_cen, share_wen, share_addr, weight_cen, weight_wen, weight_addr,
      input  act_cen, act_wen, act_addr, out_cen, out_wen, out_addr
   );

   modport slave (
      input  EN, START, W_BASE, A_BASE, O_BASE, W_LEN, A_LEN, O_LEN, NUM_TILES,
      output BUSY, DONE, ERR, TILE_IDX, W_EN, SELECTOR,
      output share_cen, share_wen, share_addr, weight_cen, weight_wen, weight_addr,
      output act_cen, act_wen, act_addr, out_cen, out_wen, out_addr
   );
endinterface

// File: rtl/tile_seq_controller_seq_counter.sv
// rtl/tile_seq_controller_seq_counter.sv - loadable in-state cycle counter with terminal-count compare
module seq_counter #(
   parameter int W = 7
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         tc
);
   // count_nxt is exported so registered outputs can be decoded for the coming cycle
   assign count_nxt = load ? load_val : count + W'(1);
   assign tc        = (count == last);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count <= '0;
      end else if (en) begin
         count <= count_nxt;
      end
   end
endmodule

// File: rtl/tile_seq_controller.sv
// rtl/tile_seq_controller.sv - multi-tile load/compute/drain/store sequencer for the systolic array
module tile_seq_controller
   import tile_seq_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int LEN_W    = 6,
   parameter int TILE_W   = 4,
   parameter int PIPE_LAT = 3
) (
   input logic CLK,
   input logic RESET,
   tile_seq_controller_if.slave bus
);
   localparam int CW = LEN_W + 1;
   localparam logic [CW-1:0] DRAIN_LAST = (PIPE_LAT > 0) ? CW'(PIPE_LAT - 1) : '0;

   seq_state_e        state, state_n;
   logic [CW-1:0]     k, k_n, k_last;
   logic              k_tc, restart;

   logic [ADDR_W-1:0] w_base_q, w_base_n, abase_q, abase_n, obase_q, obase_n;
   logic [LEN_W-1:0]  w_len_q, w_len_n, a_len_q, a_len_n, o_len_q, o_len_n, m_len;
   logic [TILE_W-1:0] tiles_q, tiles_n, tile_q, tile_n;
   logic              err_q, err_n, busy_q, busy_d, done_q, done_d, w_en_q, w_en_d, sel_q, sel_d;

   logic              share_cen_q, share_wen_q, weight_cen_q, weight_wen_q;
   logic              act_cen_q, act_wen_q, out_cen_q, out_wen_q;
   logic              share_cen_d, share_wen_d, weight_cen_d, weight_wen_d;
   logic              act_cen_d, act_wen_d, out_cen_d, out_wen_d;
   logic [ADDR_W-1:0] share_addr_q, weight_addr_q, act_addr_q, out_addr_q;
   logic [ADDR_W-1:0] share_addr_d, weight_addr_d, act_addr_d, out_addr_d;

   seq_counter #(.W(CW)) u_cnt (
      .CLK(CLK), .RESET(RESET), .en(bus.EN), .load(restart), .load_val('0),
      .last(k_last), .count(k), .count_nxt(k_n), .tc(k_tc)
   );

   assign m_len = (w_len_q > a_len_q) ? w_len_q : a_len_q;

   always_comb begin
      k_last = '0;
      case (state)
         S_LOAD_W: k_last = {1'b0, w_len_q};
         S_LOAD_A: k_last = {1'b0, m_len};
         S_CALC:   k_last = {1'b0, a_len_q} - CW'(1);
         S_DRAIN:  k_last = DRAIN_LAST;
         S_STORE:  k_last = {1'b0, o_len_q} - CW'(1);
         default:  k_last = '0;
      endcase
   end

   always_comb begin
      state_n  = state;
      restart  = 1'b0;
      w_base_n = w_base_q;
      w_len_n  = w_len_q;
      a_len_n  = a_len_q;
      o_len_n  = o_len_q;
      tiles_n  = tiles_q;
      abase_n  = abase_q;
      obase_n  = obase_q;
      tile_n   = tile_q;
      err_n    = err_q;
      case (state)
         S_IDLE: begin
            restart = 1'b1;
            if (bus.START) begin
               w_base_n = bus.W_BASE;
               w_len_n  = bus.W_LEN;
               a_len_n  = bus.A_LEN;
               o_len_n  = bus.O_LEN;
               tiles_n  = bus.NUM_TILES;
               abase_n  = bus.A_BASE;
               obase_n  = bus.O_BASE;
               tile_n   = '0;
               if (bus.W_LEN == '0 || bus.A_LEN == '0 || bus.O_LEN == '0 || bus.NUM_TILES == '0) begin
                  state_n = S_FINISH;
                  err_n   = 1'b1;
               end else begin
                  state_n = S_LOAD_W;
               end
            end
         end
         S_LOAD_W: if (k_tc) begin state_n = S_LOAD_A; restart = 1'b1; end
         S_LOAD_A: if (k_tc) begin state_n = S_CALC;   restart = 1'b1; end
         S_CALC: if (k_tc) begin
            state_n = (PIPE_LAT == 0) ? S_STORE : S_DRAIN;
            restart = 1'b1;
         end
         S_DRAIN: if (k_tc) begin state_n = S_STORE; restart = 1'b1; end
         S_STORE: if (k_tc) begin
            restart = 1'b1;
            // Weights stay resident; only the per-tile bases advance
            if (({1'b0, tile_q} + (TILE_W+1)'(1)) < {1'b0, tiles_q}) begin
               tile_n  = tile_q + TILE_W'(1);
               abase_n = abase_q + ADDR_W'(a_len_q);
               obase_n = obase_q + ADDR_W'(o_len_q);
               state_n = S_LOAD_A;
            end else begin
               state_n = S_FINISH;
            end
         end
         S_FINISH: begin
            state_n = S_IDLE;
            restart = 1'b1;
            tile_n  = '0;
            err_n   = 1'b0;
         end
         default: begin state_n = S_IDLE; restart = 1'b1; end
      endcase
   end

   // Outputs are decoded for the coming (state_n, k_n) so they register alongside the state
   always_comb begin
      share_cen_d   = CEN_OFF;  share_wen_d  = WEN_RD;  share_addr_d  = share_addr_q;
      weight_cen_d  = CEN_OFF;  weight_wen_d = WEN_RD;  weight_addr_d = weight_addr_q;
      act_cen_d     = CEN_OFF;  act_wen_d    = WEN_RD;  act_addr_d    = act_addr_q;
      out_cen_d     = CEN_OFF;  out_wen_d    = WEN_RD;  out_addr_d    = out_addr_q;
      w_en_d        = 1'b0;
      sel_d         = 1'b0;
      busy_d        = (state_n != S_IDLE);
      done_d        = (state_n == S_FINISH);
      case (state_n)
         S_LOAD_W: begin
            if (k_n < {1'b0, w_len_n}) begin
               share_cen_d = CEN_ON; share_addr_d = w_base_n + ADDR_W'(k_n);
            end
            if (k_n != '0) begin
               weight_cen_d = CEN_ON; weight_wen_d = WEN_WR; weight_addr_d = ADDR_W'(k_n - CW'(1));
            end
         end
         S_LOAD_A: begin
            w_en_d = 1'b1;
            sel_d  = 1'b1;
            if (k_n < {1'b0, a_len_n}) begin
               share_cen_d = CEN_ON; share_addr_d = abase_n + ADDR_W'(k_n);
            end
            if (k_n != '0 && k_n <= {1'b0, a_len_n}) begin
               act_cen_d = CEN_ON; act_wen_d = WEN_WR; act_addr_d = ADDR_W'(k_n - CW'(1));
            end
            if (k_n < {1'b0, w_len_n}) begin
               weight_cen_d = CEN_ON; weight_addr_d = ADDR_W'(k_n);
            end
         end
         S_CALC: begin
            act_cen_d = CEN_ON; act_addr_d = ADDR_W'(k_n);
         end
         S_STORE: begin
            out_cen_d = CEN_ON; out_wen_d = WEN_WR; out_addr_d = obase_n + ADDR_W'(k_n);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= S_IDLE;
         w_base_q <= '0; w_len_q <= '0; a_len_q <= '0; o_len_q <= '0; tiles_q <= '0;
         abase_q <= '0; obase_q <= '0; tile_q <= '0; err_q <= 1'b0;
         busy_q <= 1'b0; done_q <= 1'b0; w_en_q <= 1'b0; sel_q <= 1'b0;
         share_cen_q  <= CEN_OFF; share_wen_q  <= WEN_RD; share_addr_q  <= '0;
         weight_cen_q <= CEN_OFF; weight_wen_q <= WEN_RD; weight_addr_q <= '0;
         act_cen_q    <= CEN_OFF; act_wen_q    <= WEN_RD; act_addr_q    <= '0;
         out_cen_q    <= CEN_OFF; out_wen_q    <= WEN_RD; out_addr_q    <= '0;
      end else if (bus.EN) begin
         state <= state_n;
         w_base_q <= w_base_n; w_len_q <= w_len_n; a_len_q <= a_len_n; o_len_q <= o_len_n;
         tiles_q <= tiles_n; abase_q <= abase_n; obase_q <= obase_n; tile_q <= tile_n;
         err_q <= err_n; busy_q <= busy_d; done_q <= done_d; w_en_q <= w_en_d; sel_q <= sel_d;
         share_cen_q  <= share_cen_d;  share_wen_q  <= share_wen_d;  share_addr_q  <= share_addr_d;
         weight_cen_q <= weight_cen_d; weight_wen_q <= weight_wen_d; weight_addr_q <= weight_addr_d;
         act_cen_q    <= act_cen_d;    act_wen_q    <= act_wen_d;    act_addr_q    <= act_addr_d;
         out_cen_q    <= out_cen_d;    out_wen_q    <= out_wen_d;    out_addr_q    <= out_addr_d;
      end
   end

   assign bus.BUSY        = busy_q;
   assign bus.DONE        = done_q;
   assign bus.ERR         = err_q;
   assign bus.TILE_IDX    = tile_q;
   assign bus.W_EN        = w_en_q;
   assign bus.SELECTOR    = sel_q;
   assign bus.share_cen   = share_cen_q;
   assign bus.share_wen   = share_wen_q;
   assign bus.share_addr  = share_addr_q;
   assign bus.weight_cen  = weight_cen_q;
   assign bus.weight_wen  = weight_wen_q;
   assign bus.weight_addr = weight_addr_q;
   assign bus.act_cen     = act_cen_q;
   assign bus.act_wen     = act_wen_q;
   assign bus.act_addr    = act_addr_q;
   assign bus.out_cen     = out_cen_q;
   assign bus.out_wen     = out_wen_q;
   assign bus.out_addr    = out_addr_q;
endmodule

// File: doc/tile_seq_controller.md
Name: tile_seq_controller

Overview:
Parametrised sequencer for the systolic-array datapath. On a START handshake it performs these steps:
- copies weights from the shared buffer into the weight buffer;
- for each of NUM_TILES tiles, streams activations from the shared buffer into the activate buffer while shifting weights into the PEs;
- runs the compute pass, waits out the pipeline drain, and writes results to the output buffer.

Improvements over the fixed-length controller: runtime lengths, multi-tile looping with weight-buffer reuse, EN stall, config error flag and a BUSY/DONE handshake.

Parameters:
ADDR_W, 6, width of every buffer address.
LEN_W, 6, width of the W_LEN, A_LEN and O_LEN length fields.
TILE_W, 4, width of NUM_TILES and TILE_IDX.
PIPE_LAT, 3, drain cycles between the last activation read and the first output write (0 allowed).

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  asynchronous, active-low reset.
EN  in  1  1 = advance; 0 = freeze state, counters and all outputs.
START  in  1  start request, sampled only in IDLE with EN=1.
W_BASE, A_BASE, O_BASE  in  ADDR_W each  shared-buffer weight base, shared-buffer activation base, output-buffer base.
W_LEN, A_LEN, O_LEN  in  LEN_W each  words per weight load, per activation tile, per output tile.
NUM_TILES  in  TILE_W  number of tiles to run.
BUSY  out  1  high from the cycle after START acceptance until FINISH completes.
DONE  out  1  one-cycle pulse in FINISH.
ERR  out  1  high with DONE when the config was rejected.
TILE_IDX  out  TILE_W  current tile index.
W_EN, SELECTOR  out  1 each  PE weight-load enable and PE weight-path select.
share_cen, share_wen, share_addr  out  1,1,ADDR_W  shared buffer port.
weight_cen, weight_wen, weight_addr  out  1,1,ADDR_W  weight buffer port.
act_cen, act_wen, act_addr  out  1,1,ADDR_W  activate buffer port.
out_cen, out_wen, out_addr  out  1,1,ADDR_W  output buffer port.

Behaviour:
- Memory conventions: all memories use active-low cen and wen and have 1-cycle read latency.
- All outputs are registered.
- Reset values: state IDLE; every cen=1 and wen=1; every addr=0; W_EN=0, SELECTOR=0, BUSY=0, DONE=0, ERR=0, TILE_IDX=0.
- Reset is asynchronous and takes effect mid-operation; no memory write is issued after RESET falls.
- EN=0 in any state: nothing changes, and outputs hold their values (including asserted cens).
- States: IDLE, LOAD_W, LOAD_A, CALC, DRAIN, STORE, FINISH. In the rules below, k is the in-state cycle counter starting at 0.
- IDLE: START=1 latches all config fields.
  - If any of W_LEN, A_LEN, O_LEN or NUM_TILES is 0, go to FINISH with ERR=1 and do no memory access.
  - Otherwise go to LOAD_W.
- START while not IDLE is ignored.
- LOAD_W (W_LEN+1 cycles):
  - k<W_LEN: shared-buffer read at W_BASE+k.
  - k>=1: weight write at address k-1.
  - Executed once per run, not per tile.
- LOAD_A (M+1 cycles, where M = max(A_LEN, W_LEN)):
  - W_EN=1 and SELECTOR=1 throughout.
  - k<A_LEN: shared-buffer read at ABASE_T+k, where ABASE_T = A_BASE + TILE_IDX*A_LEN.
  - 1<=k<=A_LEN: activate write at address k-1.
  - k<W_LEN: weight read at address k.
  - ABASE_T is kept as a running accumulator; no multiplier.
- CALC (A_LEN cycles): W_EN=0 and SELECTOR=0; activate read at address k; shared buffer idle (cen=1).
- DRAIN (PIPE_LAT cycles): all memories idle. PIPE_LAT=0 skips this state.
- STORE (O_LEN cycles): output write at OBASE_T+k, where OBASE_T = O_BASE + TILE_IDX*O_LEN (accumulator).
  - At the end of STORE: if TILE_IDX+1 < NUM_TILES, increment TILE_IDX and go to LOAD_A; otherwise go to FINISH.
- FINISH (1 cycle): DONE=1 and BUSY=1, then go to IDLE with BUSY=0, ERR=0 and TILE_IDX=0.
- Address arithmetic wraps modulo 2^ADDR_W. Counters are LEN_W+1 bits wide so that a length of 2^LEN_W-1 terminates.

Decomposition:
- Package tile_seq_pkg holds the state enum encoding and the cen/wen active-low level constants.
- One sub-module, seq_counter: loadable up-counter with a terminal-count compare, shared by all state phases.

Test Plan:
- Single tile, ADDR_W=6, W_BASE=0, A_BASE=16, O_BASE=32, all lengths 4, NUM_TILES=1, PIPE_LAT=3 -> START to DONE takes 21 state cycles plus FINISH. Weight writes at 0..3, activate writes at 0..3, output writes at 32..35, W_EN high exactly 5 cycles. DONE is 1 cycle wide.
- Same config with NUM_TILES=2 -> LOAD_W occurs once. Second tile reads the shared buffer at 20..23 and writes outputs at 36..39. TILE_IDX reads 1 during tile 2.
- W_BASE=62, W_LEN=4 -> shared-buffer reads at 62, 63, 0, 1.
- EN=0 for 3 cycles mid-LOAD_A -> addresses and cens held. Total latency +3 cycles; write sequence unchanged.
- A_LEN=0 -> DONE=1 and ERR=1 the cycle after START, with no cen asserted. START pulsed while BUSY -> ignored, and only one DONE is produced.
- RESET low during CALC -> all outputs take reset values immediately. A new START after reset runs a full sequence.
